// File: rtl/add_arb2.sv
// ---------------------------------------------------------------------------
// add_arb2 -- two-requester arbiter in front of one shared 8-bit adder.
//
// Each requester presents an operand pair (a, b) with a request. One request
// is accepted per cycle, and the choice between two simultaneous requests
// alternates. The accepted pair goes through the one adder. Its sum is
// registered and tagged with the owning requester one clock after the accept.
//
// Ports
//   clock        in   single clock; all state changes on the rising edge
//   reset        in   synchronous, active-high reset
//   req0/a0/b0   in   requester 0 request and unsigned operands
//   req1/a1/b1   in   requester 1 request and unsigned operands
//   gnt0/gnt1    out  combinational grants; req & gnt high means accept
//   s            out  registered sum of the last accepted pair (mod 256)
//   vld0/vld1    out  registered; s belongs to requester 0/1 this cycle
//   cnt0/cnt1    out  registered accept counters that wrap at 256
// ---------------------------------------------------------------------------
module add_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic       req1,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [7:0] s,
  output logic       vld0,
  output logic       vld1,
  output logic [7:0] cnt0,
  output logic [7:0] cnt1
);

  // PRI0: requester 0 wins a tie. PRI1: requester 1 wins a tie.
  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } state_e;

  state_e     state_q;
  logic [7:0] s_q;
  logic       vld0_q;
  logic       vld1_q;
  logic [7:0] cnt0_q;
  logic [7:0] cnt1_q;

  logic       gnt0_d;
  logic       gnt1_d;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] sum_d;

  // Grant and operand selection. A grant is only raised for an active request,
  // so the grant alone marks an accept. Only one requester can be granted per
  // cycle, because the tie goes to the preferred side.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through this block
    // leaves a signal unassigned. Without the defaults a latch is inferred.
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    op_a   = a1;
    op_b   = b1;
    if (state_q == PRI0) begin
      gnt0_d = req0;
      gnt1_d = req1 & ~req0;
    end else begin
      gnt1_d = req1;
      gnt0_d = req0 & ~req1;
    end
    // The operands are muxed in front of the adder, so one adder serves both
    // requesters. The carry-out is dropped by the 8-bit result.
    if (gnt0_d) begin
      op_a = a0;
      op_b = b0;
    end
    sum_d = op_a + op_b;
  end

  // State, result and counters. Reset takes priority, so an accept in the
  // same cycle as reset is discarded and raises no vld.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    if (reset) begin
      state_q <= PRI0;
      s_q     <= 8'd0;
      vld0_q  <= 1'b0;
      vld1_q  <= 1'b0;
      cnt0_q  <= 8'd0;
      cnt1_q  <= 8'd0;
    end else begin
      vld0_q <= gnt0_d;
      vld1_q <= gnt1_d;
      if (gnt0_d || gnt1_d) begin
        s_q <= sum_d;
      end
      if (gnt0_d) begin
        cnt0_q  <= cnt0_q + 8'd1;
        state_q <= PRI1;
      end else if (gnt1_d) begin
        cnt1_q  <= cnt1_q + 8'd1;
        state_q <= PRI0;
      end
    end
  end

  assign gnt0 = gnt0_d;
  assign gnt1 = gnt1_d;
  assign s    = s_q;
  assign vld0 = vld0_q;
  assign vld1 = vld1_q;
  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;

endmodule

// File: doc/add_arb2.md
ADD_ARB2 -- requirements
Module: add_arb2

Interface
REQ-001 clock  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset; sampled only on rising edge of clock.
REQ-003 req0  input  1  requester 0 operation request; held high with operands stable until granted.
REQ-004 a0  input  8  requester 0 operand A, unsigned.
REQ-005 b0  input  8  requester 0 operand B, unsigned.
REQ-006 req1  input  1  requester 1 operation request; same rules as req0.
REQ-007 a1  input  8  requester 1 operand A, unsigned.
REQ-008 b1  input  8  requester 1 operand B, unsigned.
REQ-009 gnt0  output  1  combinational grant to requester 0; accept occurs in any cycle with req0 and gnt0 both high.
REQ-010 gnt1  output  1  combinational grant to requester 1; same rules as gnt0.
REQ-011 s  output  8  registered sum of the accepted operand pair.
REQ-012 vld0  output  1  registered; s belongs to requester 0 this cycle.
REQ-013 vld1  output  1  registered; s belongs to requester 1 this cycle.
REQ-014 cnt0  output  8  registered count of requester 0 accepts, wraps 255 -> 0.
REQ-015 cnt1  output  8  registered count of requester 1 accepts, wraps 255 -> 0.

Function
REQ-016 The block shall contain one shared 8-bit adder followed by one 8-bit result register; it shall accept at most one operation per cycle.
REQ-017 Arbitration FSM shall have two states: PRI0 (requester 0 preferred) and PRI1 (requester 1 preferred).
REQ-018 In PRI0: req0 high -> gnt0=1, gnt1=0; req0 low and req1 high -> gnt1=1, gnt0=0; neither -> both 0.
REQ-019 In PRI1: symmetric; requester 1 preferred.
REQ-020 Transition: accept for requester 0 -> next state PRI1; accept for requester 1 -> next state PRI0; no accept -> state unchanged.
REQ-021 gnt0 and gnt1 shall never be high in the same cycle.
REQ-022 Neither grant shall be high while its req is low.
REQ-023 Result: an accept at edge k shall load s = (a + b) mod 256 of the granted operands at edge k.
REQ-024 The matching vld bit shall be high for exactly the cycle following edge k; latency is 1 clock and carry-out is discarded.
REQ-025 With no accept at edge k, vld0 and vld1 shall both be 0 after edge k, and s shall hold its previous value.
REQ-026 Continuous requests from both requesters shall alternate grants 0,1,0,1... with an accept every cycle and no idle cycle.
REQ-027 A single continuous requester shall be granted every cycle regardless of FSM state.
REQ-028 cnt0 and cnt1 shall each increment by 1 at edges where their requester is accepted; 255 shall wrap to 0.
REQ-029 A requester dropping req before grant shall be permitted; no accept occurs and no state changes.

Reset
REQ-030 While reset is high at an edge: s=0, vld0=0, vld1=0, cnt0=0, cnt1=0, state=PRI0.
REQ-031 Reset shall take precedence over any simultaneous accept; that operation is discarded and no vld is issued.
REQ-032 Grants shall remain combinational during reset and shall follow REQ-018 from state PRI0 after the reset edge.

Verification
REQ-033 Reset then idle -> s=0, vld0=vld1=0, cnt0=cnt1=0, gnt0=gnt1=0.
REQ-034 After reset, req0=1 (a0=0x12, b0=0x34) for one cycle -> gnt0=1 that cycle; next cycle s=0x46, vld0=1, cnt0=1, state PRI1.
REQ-035 Both req high for 4 cycles, a0=b0=0x01, a1=b1=0x80 -> grants 0,1,0,1; s sequence 0x02,0x00,0x02,0x00 with vld0,vld1 alternating; cnt0=cnt1=2.
REQ-036 req1 only, a1=0xFF, b1=0x02, held 256 cycles -> s=0x01 with vld1 high every cycle; cnt1 wraps to 0.
REQ-037 Both req high and reset asserted in the same cycle -> no vld next cycle; s=0; state PRI0; gnt0 granted first after reset.
REQ-038 Random req/operands over 10k cycles with a scoreboard -> every accept yields exactly one correct tagged sum one cycle later; no double grant; no starvation beyond 1 cycle.
